// File: rtl/simd_addsub_pkg.sv
// Shared definitions for the SIMD add/sub pipeline.
//   MODE_*  : operation select encodings driven on the mode port
//   state_t : controller state encoding (ST_IDLE, ST_RED)
package simd_addsub_pkg;

  localparam logic [1:0] MODE_ADD    = 2'b00;
  localparam logic [1:0] MODE_SUB    = 2'b01;
  localparam logic [1:0] MODE_PADDSB = 2'b10;
  localparam logic [1:0] MODE_RED    = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RED  = 1'b1
  } state_t;

endpackage

// File: rtl/lane_sat_add.sv
// One LANE-bit slice of the SIMD adder, purely combinational.
//   a, b        : lane operands (b already inverted by the caller for subtract)
//   cin         : carry from the lane below (or the subtract carry for lane 0)
//   chain_break : ignore cin so the lane adds on its own
//   sat_en      : clamp sum_sat on signed overflow
//   sum_raw     : unsaturated lane sum
//   sum_sat     : sum_raw, or the signed limit when sat_en and overflow
//   cout        : carry out of the lane MSB
//   pos_ovf     : signed overflow toward +inf
//   neg_ovf     : signed overflow toward -inf
module lane_sat_add #(
  parameter int LANE = 4
) (
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  input  logic            cin,
  input  logic            chain_break,
  input  logic            sat_en,
  output logic [LANE-1:0] sum_raw,
  output logic [LANE-1:0] sum_sat,
  output logic            cout,
  output logic            pos_ovf,
  output logic            neg_ovf
);

  logic            cin_eff;
  logic [LANE:0]   full;

  assign cin_eff = cin & ~chain_break;
  assign full    = {1'b0, a} + {1'b0, b} + {{LANE{1'b0}}, cin_eff};
  assign sum_raw = full[LANE-1:0];
  assign cout    = full[LANE];

  // Same-sign operands producing an opposite-sign result is a signed overflow.
  assign pos_ovf = ~a[LANE-1] & ~b[LANE-1] &  sum_raw[LANE-1];
  assign neg_ovf =  a[LANE-1] &  b[LANE-1] & ~sum_raw[LANE-1];

  always_comb begin
    sum_sat = sum_raw;
    if (sat_en && pos_ovf) begin
      sum_sat = {1'b0, {(LANE-1){1'b1}}};
    end else if (sat_en && neg_ovf) begin
      sum_sat = {1'b1, {(LANE-1){1'b0}}};
    end
  end

endmodule

// File: rtl/simd_addsub_pipe.sv
// Handshaked SIMD add/sub unit: saturating ADD/SUB, per-lane saturating
// PADDSB, and a sequential lane reduction (RED), results registered behind
// a valid/ready output.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake; a, b, mode captured on transfer
//   out_valid/out_ready : result handshake
//   sum, cout, ov     : result, raw full-width carry (ADD/SUB), overflow/saturation
//   lane_sat          : per-lane saturation flags, only when
//                       SIMD_ADDSUB_LANE_FLAGS_EN is defined
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a new op; non-RED ops complete at the accept edge
// ST_RED  | accumulating one lane of a and b per cycle
module simd_addsub_pipe
  import simd_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ov
`ifdef SIMD_ADDSUB_LANE_FLAGS_EN
  ,
  output logic [WIDTH/LANE-1:0] lane_sat
`endif
);

  localparam int NLANES = WIDTH / LANE;
  localparam int LCW    = $clog2(NLANES);
  localparam logic [LCW-1:0]   LAST_LANE = LCW'(NLANES - 1);
  localparam logic [WIDTH-1:0] SAT_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  logic              is_sub;
  logic              is_paddsb;
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  sum_raw;
  logic [WIDTH-1:0]  sum_sat;
  logic [NLANES:0]   carry;
  logic [NLANES-1:0] pos_ovf;
  logic [NLANES-1:0] neg_ovf;
  logic [NLANES-1:0] lane_ovf;

  assign is_sub    = (mode == MODE_SUB);
  assign is_paddsb = (mode == MODE_PADDSB);
  assign b_eff     = b ^ {WIDTH{is_sub}};
  assign carry[0]  = is_sub;
  assign lane_ovf  = pos_ovf | neg_ovf;

  // PADDSB never subtracts, so breaking every lane's chain (lane 0 included)
  // is harmless and keeps the connection uniform.
  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    lane_sat_add #(.LANE(LANE)) u_lane (
      .a          (a[g*LANE +: LANE]),
      .b          (b_eff[g*LANE +: LANE]),
      .cin        (carry[g]),
      .chain_break(is_paddsb),
      .sat_en     (is_paddsb),
      .sum_raw    (sum_raw[g*LANE +: LANE]),
      .sum_sat    (sum_sat[g*LANE +: LANE]),
      .cout       (carry[g+1]),
      .pos_ovf    (pos_ovf[g]),
      .neg_ovf    (neg_ovf[g])
    );
  end

  // Single-cycle result for ADD/SUB/PADDSB. With the chain unbroken, the top
  // lane's overflow detection is the full-width signed overflow.
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ov;

  always_comb begin
    res_sum  = sum_raw;
    res_cout = 1'b0;
    res_ov   = 1'b0;
    case (mode)
      MODE_ADD, MODE_SUB: begin
        res_cout = carry[NLANES];
        if (pos_ovf[NLANES-1]) begin
          res_sum = SAT_POS;
          res_ov  = 1'b1;
        end else if (neg_ovf[NLANES-1]) begin
          res_sum = SAT_NEG;
          res_ov  = 1'b1;
        end
      end
      MODE_PADDSB: begin
        res_sum = sum_sat;
        res_ov  = |lane_ovf;
      end
      default: res_sum = '0;
    endcase
  end

  // Registers
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [LCW-1:0]    lane_q, lane_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ov_q, ov_d;

  logic              accept;
  logic [LANE-1:0]   a_lane;
  logic [LANE-1:0]   b_lane;
  logic [WIDTH-1:0]  acc_next;

  assign in_ready = (state_q == ST_IDLE) & (~out_valid_q | out_ready) & ~rst;
  assign accept   = in_valid & in_ready;

  assign a_lane   = a_q[lane_q*LANE +: LANE];
  assign b_lane   = b_q[lane_q*LANE +: LANE];
  assign acc_next = acc_q
                  + {{(WIDTH-LANE){a_lane[LANE-1]}}, a_lane}
                  + {{(WIDTH-LANE){b_lane[LANE-1]}}, b_lane};

`ifdef SIMD_ADDSUB_LANE_FLAGS_EN
  logic [NLANES-1:0] res_flags;
  logic [NLANES-1:0] lane_sat_q, lane_sat_d;

  always_comb begin
    res_flags = '0;
    case (mode)
      MODE_ADD, MODE_SUB: res_flags = {NLANES{res_ov}};
      MODE_PADDSB:        res_flags = lane_ovf;
      default:            res_flags = '0;
    endcase
  end
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ov_d        = ov_q;
`ifdef SIMD_ADDSUB_LANE_FLAGS_EN
    lane_sat_d  = lane_sat_q;
`endif

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (mode == MODE_RED) begin
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
            lane_d  = '0;
            state_d = ST_RED;
          end else begin
            out_valid_d = 1'b1;
            sum_d       = res_sum;
            cout_d      = res_cout;
            ov_d        = res_ov;
`ifdef SIMD_ADDSUB_LANE_FLAGS_EN
            lane_sat_d  = res_flags;
`endif
          end
        end
      end
      ST_RED: begin
        acc_d  = acc_next;
        lane_d = lane_q + 1'b1;
        if (lane_q == LAST_LANE) begin
          lane_d      = '0;
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          sum_d       = acc_next;
          cout_d      = 1'b0;
          ov_d        = 1'b0;
`ifdef SIMD_ADDSUB_LANE_FLAGS_EN
          lane_sat_d  = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      lane_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ov_q        <= ov_d;
    end
  end

`ifdef SIMD_ADDSUB_LANE_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_sat_q <= '0;
    end else begin
      lane_sat_q <= lane_sat_d;
    end
  end

  assign lane_sat = lane_sat_q;
`endif

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ov        = ov_q;

endmodule
